// File: rtl/axi_master_pkg.sv
// Shared types and constants for the single-outstanding AXI3 burst initiator.
package axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam int unsigned BOUNDARY_4K = 32'd4096;

  // A burst may touch the last byte of a 4 KiB page but not the first byte of the next one.
  function automatic logic crosses_4k(input logic [11:0] offset, input logic [3:0] len,
                                      input int unsigned bytes);
    int unsigned end_byte;
    end_byte = 32'(offset) + (32'(len) + 32'd1) * bytes;
    return (end_byte > BOUNDARY_4K);
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mst_beat_cnt.sv
// Beat counter shared by the write and read data phases; flags the beat whose index equals len.
module axi_mst_beat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       incr,
  input  logic [3:0] len,
  output logic       last
);

  logic [3:0] cnt_r;

  // Saturating at 15 keeps an over-long slave burst from wrapping back onto a valid "last" index.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= 4'd0;
    end else if (incr && (cnt_r != 4'hF)) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == len);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI3 INCR burst initiator with one completion pulse per command.
// Optional page-crossing rejection is enabled by defining AXI_MASTER_4K_CHECK_EN.
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      axi_clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [7:0]                cmd_id_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [3:0]                cmd_len_i,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      rd_last_o,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic                      done_valid_o,
  output logic [1:0]                done_resp_o,
  output logic [7:0]                axi_awid_o,
  output logic [ADDR_WIDTH-1:0]     axi_awaddr_o,
  output logic [3:0]                axi_awlen_o,
  output logic                      axi_awvalid_o,
  input  logic                      axi_awready_i,
  output logic [7:0]                axi_wid_o,
  output logic [DATA_WIDTH-1:0]     axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   axi_wstrb_o,
  output logic                      axi_wlast_o,
  output logic                      axi_wvalid_o,
  input  logic                      axi_wready_i,
  input  logic [7:0]                axi_bid_i,
  input  logic [1:0]                axi_bresp_i,
  input  logic                      axi_bvalid_i,
  output logic                      axi_bready_o,
  output logic [7:0]                axi_arid_o,
  output logic [ADDR_WIDTH-1:0]     axi_araddr_o,
  output logic [3:0]                axi_arlen_o,
  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  input  logic [7:0]                axi_rid_i,
  input  logic [DATA_WIDTH-1:0]     axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rlast_i,
  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  state_e                state_r, state_n;
  logic [7:0]            id_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [3:0]            len_r;
  logic [1:0]            resp_r, resp_n;
  logic                  cmd_ready_s, cmd_acc_s, cross_s, last_s;
  logic                  cnt_clr_s, cnt_inc_s;
  logic                  awvalid_s, wvalid_s, wready_s, bready_s;
  logic                  arvalid_s, rvalid_s, rready_s, done_s;

`ifdef AXI_MASTER_4K_CHECK_EN
  assign cross_s = crosses_4k(cmd_addr_i[11:0], cmd_len_i, BYTES);
`else
  assign cross_s = 1'b0;
`endif

  assign cmd_acc_s = (state_r == ST_IDLE) && cmd_valid_i;

  axi_mst_beat_cnt u_beat_cnt (
    .clk   (axi_clk_i),
    .rst   (rst_i),
    .clear (cnt_clr_s),
    .incr  (cnt_inc_s),
    .len   (len_r),
    .last  (last_s)
  );

  // Next-state, response accumulation and per-state handshake enables.
  always_comb begin
    state_n     = state_r;
    resp_n      = resp_r;
    cmd_ready_s = 1'b0;
    awvalid_s   = 1'b0;
    wvalid_s    = 1'b0;
    wready_s    = 1'b0;
    bready_s    = 1'b0;
    arvalid_s   = 1'b0;
    rvalid_s    = 1'b0;
    rready_s    = 1'b0;
    done_s      = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (cmd_valid_i) begin
          resp_n = RESP_OKAY;
          if (cross_s) begin
            state_n = ST_DONE;
            resp_n  = RESP_SLVERR;
          end else if (cmd_write_i) begin
            state_n = ST_AW;
          end else begin
            state_n = ST_AR;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_AW: begin
        awvalid_s = 1'b1;
        if (axi_awready_i) begin
          state_n   = ST_W;
          cnt_clr_s = 1'b1;
        end else begin
          state_n = ST_AW;
        end
      end
      ST_W: begin
        wvalid_s = wr_valid_i;
        wready_s = axi_wready_i;
        if (wr_valid_i && axi_wready_i) begin
          cnt_inc_s = 1'b1;
          state_n   = last_s ? ST_B : ST_W;
        end else begin
          state_n = ST_W;
        end
      end
      ST_B: begin
        bready_s = 1'b1;
        if (axi_bvalid_i) begin
          resp_n  = (axi_bid_i != id_r) ? RESP_SLVERR : axi_bresp_i;
          state_n = ST_DONE;
        end else begin
          state_n = ST_B;
        end
      end
      ST_AR: begin
        arvalid_s = 1'b1;
        if (axi_arready_i) begin
          state_n   = ST_R;
          cnt_clr_s = 1'b1;
        end else begin
          state_n = ST_AR;
        end
      end
      ST_R: begin
        rvalid_s = axi_rvalid_i;
        rready_s = rd_ready_i;
        if (axi_rvalid_i && rd_ready_i) begin
          cnt_inc_s = 1'b1;
          // Early rlast, missing rlast at the final index, or a foreign ID all flag the burst.
          if ((axi_rlast_i != last_s) || (axi_rid_i != id_r)) begin
            resp_n = RESP_SLVERR;
          end else begin
            resp_n = resp_max(resp_r, axi_rresp_i);
          end
          state_n = axi_rlast_i ? ST_DONE : ST_R;
        end else begin
          state_n = ST_R;
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, latched command fields and accumulated response.
  always_ff @(posedge axi_clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      id_r    <= 8'd0;
      addr_r  <= '0;
      len_r   <= 4'd0;
      resp_r  <= 2'b00;
    end else begin
      state_r <= state_n;
      resp_r  <= resp_n;
      if (cmd_acc_s) begin
        id_r   <= cmd_id_i;
        addr_r <= cmd_addr_i;
        len_r  <= cmd_len_i;
      end else begin
        id_r   <= id_r;
        addr_r <= addr_r;
        len_r  <= len_r;
      end
    end
  end

  assign cmd_ready_o   = cmd_ready_s & ~rst_i;
  assign axi_awid_o    = id_r;
  assign axi_awaddr_o  = addr_r;
  assign axi_awlen_o   = len_r;
  assign axi_awvalid_o = awvalid_s;
  assign axi_wid_o     = id_r;
  assign axi_wdata_o   = wr_data_i;
  assign axi_wstrb_o   = wr_strb_i;
  assign axi_wlast_o   = (state_r == ST_W) && last_s;
  assign axi_wvalid_o  = wvalid_s;
  assign wr_ready_o    = wready_s;
  assign axi_bready_o  = bready_s;
  assign axi_arid_o    = id_r;
  assign axi_araddr_o  = addr_r;
  assign axi_arlen_o   = len_r;
  assign axi_arvalid_o = arvalid_s;
  assign axi_rready_o  = rready_s;
  assign rd_valid_o    = rvalid_s;
  assign rd_data_o     = axi_rdata_i;
  assign rd_last_o     = (state_r == ST_R) && axi_rlast_i;
  assign done_valid_o  = done_s;
  assign done_resp_o   = resp_r;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed plus randomized bench for axi_burst_master with an in-bench AXI slave memory.
// Define AXI_MASTER_4K_CHECK_EN to exercise the page-crossing rejection build.
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [7:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rlast, rvalid, rready;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] wdat [16];

  axi_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .axi_clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .done_valid_o(done_valid), .done_resp_o(done_resp),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wid_o(wid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = 8'd0; cmd_addr = 32'd0; cmd_len = 4'd0;
    wr_data = 32'd0; wr_strb = 4'hF; wr_valid = 1'b0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 8'd0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rid = 8'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_valids"}, 64'({awvalid, wvalid, bready, arvalid, rd_valid, done_valid, wr_ready}), 64'd0);
  endtask

  task automatic issue_cmd(input logic wr, input logic [7:0] id, input logic [31:0] a, input logic [3:0] len);
    int t = 0;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] exp, input string tag);
    int t = 0;
    while (!done_valid && t < 50) begin tick(); t++; end
    chk({tag, "_done_seen"}, 64'(done_valid), 64'd1);
    chk({tag, "_done_resp"}, 64'(done_resp), 64'(exp));
    tick();
    chk({tag, "_done_pulse"}, 64'(done_valid), 64'd0);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [1:0] b_resp, input bit bid_bad, input int rdy_pct,
                          input int rst_beat);
    int beat = 0;
    int t = 0;
    bit aw_ok = 1'b0;
    issue_cmd(1'b1, id, a, len);
    wr_valid = 1'b1; wr_data = wdat[0];
    while (!aw_ok && t < 100) begin
      awready = ($urandom_range(99) < rdy_pct);
      #1;
      chk("w_before_aw", 64'(wvalid), 64'd0);
      if (awready && awvalid) begin
        chk("awaddr", 64'(awaddr), 64'(a));
        chk("awlen", 64'(awlen), 64'(len));
        chk("awid", 64'(awid), 64'(id));
        aw_ok = 1'b1;
      end
      tick(); t++;
    end
    awready = 1'b0;
    chk("aw_accept", 64'(aw_ok), 64'd1);
    t = 0;
    while (beat <= int'(len) && t < 300) begin
      if (beat == rst_beat) begin
        rst = 1'b1; wr_valid = 1'b1; wready = 1'b1;
        tick();
        chk_all_quiet("rst_mid");
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        rst = 1'b0; wr_valid = 1'b0; wready = 1'b0;
        tick();
        chk("rst_release_ready", 64'(cmd_ready), 64'd1);
        return;
      end
      wr_valid = ($urandom_range(99) < 80);
      wr_data  = wdat[beat];
      wready   = ($urandom_range(99) < rdy_pct);
      #1;
      chk("wvalid_pass", 64'(wvalid), 64'(wr_valid));
      chk("wready_pass", 64'(wr_ready), 64'(wready));
      if (wvalid && wready) begin
        chk("wdata", 64'(wdata), 64'(wdat[beat]));
        chk("wlast", 64'(wlast), 64'(beat == int'(len)));
        chk("wid", 64'(wid), 64'(id));
        slave_mem[a + 32'(4 * beat)] = wdata;
        ref_mem[a + 32'(4 * beat)]   = wdat[beat];
        beat++;
      end
      tick(); t++;
    end
    wr_valid = 1'b0; wready = 1'b0;
    chk("w_beats", 64'(beat), 64'(int'(len) + 1));
    repeat ($urandom_range(2)) begin
      #1;
      chk("bready_wait", 64'(bready), 64'd1);
      tick();
    end
    bvalid = 1'b1; bresp = b_resp; bid = bid_bad ? (id ^ 8'h01) : id;
    #1;
    chk("bready", 64'(bready), 64'd1);
    tick();
    bvalid = 1'b0;
    wait_done(bid_bad ? 2'b10 : b_resp, "wr");
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                         input int rlast_at, input bit rid_bad, input int rdy_pct, input int stall_at);
    int k = 0;
    int t = 0;
    int stall = 0;
    bit fin = 1'b0;
    bit ar_ok = 1'b0;
    logic [1:0] exp = 2'b00;
    issue_cmd(1'b0, id, a, len);
    while (!ar_ok && t < 100) begin
      arready = ($urandom_range(99) < 70);
      #1;
      chk("arvalid", 64'(arvalid), 64'd1);
      if (arready) begin
        chk("araddr", 64'(araddr), 64'(a));
        chk("arlen", 64'(arlen), 64'(len));
        chk("arid", 64'(arid), 64'(id));
        ar_ok = 1'b1;
      end
      tick(); t++;
    end
    arready = 1'b0;
    chk("ar_accept", 64'(ar_ok), 64'd1);
    t = 0;
    while (!fin && t < 300) begin
      rvalid = ($urandom_range(99) < 75);
      rid    = rid_bad ? (id ^ 8'h01) : id;
      rdata  = slave_rd(a + 32'(4 * k));
      rlast  = (k == rlast_at);
      rresp  = 2'($urandom_range(1));
      if (k == stall_at && stall < 3) begin
        rd_ready = 1'b0; stall++;
      end else begin
        rd_ready = ($urandom_range(99) < rdy_pct);
      end
      #1;
      chk("rready_track", 64'(rready), 64'(rd_ready));
      chk("rvalid_pass", 64'(rd_valid), 64'(rvalid));
      if (rvalid && rd_ready) begin
        chk("rd_data", 64'(rd_data), 64'(ref_rd(a + 32'(4 * k))));
        chk("rd_last", 64'(rd_last), 64'(k == rlast_at));
        if (rresp > exp) exp = rresp;
        fin = (k == rlast_at);
        k++;
      end
      tick(); t++;
    end
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
    chk("r_complete", 64'(fin), 64'd1);
    if (rlast_at != int'(len) || rid_bad) exp = 2'b10;
    wait_done(exp, "rd");
  endtask

  task automatic load_test1();
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
  endtask

  initial begin
    logic [31:0] ra;
    logic [3:0]  rl;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk_all_quiet("reset");
    rst = 1'b0;
    tick();
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_reset_resp", 64'(done_resp), 64'd0);

    // reset and command together: the command must be dropped
    rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    tick();
    rst = 1'b0; cmd_valid = 1'b0;
    tick();
    chk("rst_wins_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wins_ready", 64'(cmd_ready), 64'd1);

    // 1 and 2: basic write then read-back
    load_test1();
    do_write(8'h05, 32'h8000_0000, 4'd3, 2'b00, 1'b0, 100, -1);
    do_read(8'h06, 32'h8000_0000, 4'd3, 3, 1'b0, 100, -1);

    // 3: random sizes with ready gaps and a 3-cycle read stall
    for (int i = 0; i < 5; i++) begin
      ra = 32'h8000_1000 + 32'($urandom_range(15) * 64);
      rl = 4'($urandom_range(15));
      for (int j = 0; j < 16; j++) wdat[j] = $urandom;
      do_write(8'($urandom_range(255)), ra, rl, 2'b00, 1'b0, 60, -1);
      do_read(8'($urandom_range(255)), ra, rl, int'(rl), 1'b0, 70, int'(rl) / 2);
    end

    // 4: error responses from the slave
    load_test1();
    do_write(8'h21, 32'h8000_0000, 4'd3, 2'b10, 1'b0, 100, -1);
    do_write(8'h22, 32'h8000_0000, 4'd3, 2'b00, 1'b1, 100, -1);
    do_read(8'h23, 32'h8000_0000, 4'd3, 1, 1'b0, 100, -1);
    chk("after_err_idle", 64'(cmd_ready), 64'd1);
    do_read(8'h24, 32'h8000_0000, 4'd3, 3, 1'b1, 100, -1);

    // 5: burst running past a 4 KiB page
`ifdef AXI_MASTER_4K_CHECK_EN
    wr_valid = 1'b1; wready = 1'b1;
    issue_cmd(1'b1, 8'h30, 32'h8000_0FF8, 4'd3);
    chk("4k_done", 64'(done_valid), 64'd1);
    chk("4k_resp", 64'(done_resp), 64'h2);
    chk("4k_no_aw", 64'(awvalid), 64'd0);
    chk("4k_no_wready", 64'(wr_ready), 64'd0);
    tick();
    chk("4k_pulse", 64'(done_valid), 64'd0);
    wr_valid = 1'b0; wready = 1'b0;
`else
    for (int j = 0; j < 4; j++) wdat[j] = $urandom;
    do_write(8'h30, 32'h8000_0FF8, 4'd3, 2'b00, 1'b0, 100, -1);
`endif

    // 6: reset during the second write beat, then a clean repeat of test 1
    load_test1();
    do_write(8'h40, 32'h8000_2000, 4'd3, 2'b00, 1'b0, 100, 1);
    do_write(8'h05, 32'h8000_0000, 4'd3, 2'b00, 1'b0, 100, -1);
    do_read(8'h06, 32'h8000_0000, 4'd3, 3, 1'b0, 100, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
